// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the memory stage (store/load sizes, result select, FSM states, misalign rule)
package lsu_pkg;
  typedef enum logic [1:0] {SW = 2'b00, SH = 2'b01, SB = 2'b10} store_src_e;
  typedef enum logic [2:0] {LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011, LBU = 3'b100} load_src_e;
  typedef enum logic {IDLE, BUSY} state_e;
  localparam logic [2:0] RES_MEM = 3'b001;
  function automatic logic misaligned(input logic mem_write, input logic [1:0] store_src,
                                      input logic [2:0] load_src, input logic [1:0] off);
    return mem_write ? (store_src == SW ? |off : store_src == SH & off[0])
                     : (load_src == LW ? |off : (load_src == LH | load_src == LHU) & off[0]);
  endfunction
endpackage

// File: rtl/lsu_mem_stage_load_extend.sv
// load_extend: picks the addressed byte/half of a read word (rdata, off, load_src) and sign/zero-extends it into ext
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      load_src,
  output logic [XLEN-1:0] ext
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = off == 2'd0 ? rdata[7:0] : off == 2'd1 ? rdata[15:8] : off == 2'd2 ? rdata[23:16] : rdata[31:24];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    ext = load_src == LH  ? {{(XLEN-16){h[15]}}, h} :
          load_src == LHU ? {{(XLEN-16){1'b0}}, h} :
          load_src == LB  ? {{(XLEN-8){b[7]}}, b} :
          load_src == LBU ? {{(XLEN-8){1'b0}}, b} : rdata;
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RISC-V memory stage with E->M/M->W registers, req/ack dmem port (addr/we/be/wdata aligned, rdata extended), StallMem while an access is pending; MISALIGN_TRAP_EN adds a sticky MisalignM and suppresses misaligned accesses
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RWIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic [2:0]        ResultSrcE,
  input  logic [XLEN-1:0]   ALUResultE,
  input  logic [XLEN-1:0]   WriteDataE,
  input  logic [RWIDTH-1:0] RdE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [1:0]        StoreSrcE,
  input  logic [2:0]        LoadSrcE,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [RWIDTH-1:0] RdM,
  output logic              RegWriteM,
  output logic              StallMem,
  output logic              DmemReq,
  output logic              DmemWe,
  output logic [XLEN-1:0]   DmemAddr,
  output logic [XLEN-1:0]   DmemWdata,
  output logic [3:0]        DmemBe,
  input  logic              DmemAck,
  input  logic [XLEN-1:0]   DmemRdata,
  output logic              RegWriteW,
  output logic [RWIDTH-1:0] RdW,
  output logic [2:0]        ResultSrcW,
  output logic [XLEN-1:0]   ALUResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   PCPlus4W
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              MisalignM
`endif
);
  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic [2:0]        result_src;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [RWIDTH-1:0] rd;
    logic [XLEN-1:0]   pc_plus4;
    logic [1:0]        store_src;
    logic [2:0]        load_src;
  } m_t;
  typedef struct packed {
    logic              reg_write;
    logic [RWIDTH-1:0] rd;
    logic [2:0]        result_src;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [XLEN-1:0]   pc_plus4;
  } w_t;
  m_t m_q, m_d;
  w_t w_q, w_d;
  state_e state_q, state_d;
  logic [1:0] off;
  logic mem_op, mis, ack;
  logic [XLEN-1:0] ext;
  assign off    = m_q.alu_result[1:0];
  assign mem_op = m_q.mem_write | (m_q.result_src == RES_MEM);
  assign ack    = DmemReq & DmemAck;
`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign mis       = mem_op & misaligned(m_q.mem_write, m_q.store_src, m_q.load_src, off);
  assign MisalignM = misalign_q;
  always_comb misalign_d = misalign_q | mis;
  always_ff @(posedge clk) misalign_q <= reset ? 1'b0 : misalign_d;
`else
  assign mis = 1'b0;
`endif
  load_extend #(.XLEN(XLEN)) u_ext (
    .rdata    (DmemRdata),
    .off      (off),
    .load_src (m_q.load_src),
    .ext      (ext)
  );
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    m_q     <= reset ? '0 : m_d;
    w_q     <= reset ? '0 : w_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (DmemReq & ~DmemAck ? BUSY : IDLE) : (DmemAck ? IDLE : BUSY);
  end
  // M holds in BUSY, so the request stays up with identical address/data until the ack
  always_comb begin
    DmemReq   = (state_q == BUSY) | (mem_op & ~mis);
    DmemWe    = DmemReq & m_q.mem_write;
    StallMem  = mem_op & DmemReq & ~DmemAck;
    DmemAddr  = {m_q.alu_result[XLEN-1:2], 2'b00};
    DmemBe    = ~m_q.mem_write ? 4'b1111 :
                m_q.store_src == SB ? 4'b0001 << off :
                m_q.store_src == SH ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    DmemWdata = m_q.store_src == SB ? {(XLEN/8){m_q.write_data[7:0]}} :
                m_q.store_src == SH ? {(XLEN/16){m_q.write_data[15:0]}} : m_q.write_data;
  end
  always_comb begin
    m_d = StallMem ? m_q : m_t'({RegWriteE, MemWriteE, ResultSrcE, ALUResultE, WriteDataE,
                                 RdE, PCPlus4E, StoreSrcE, LoadSrcE});
    w_d = w_t'({m_q.reg_write & ~m_q.mem_write & ~StallMem & ~mis, m_q.rd, m_q.result_src,
                m_q.alu_result, ack ? ext : w_q.read_data, m_q.pc_plus4});
  end
  assign ALUResultM = m_q.alu_result;
  assign RdM        = m_q.rd;
  assign RegWriteM  = m_q.reg_write;
  assign RegWriteW  = w_q.reg_write;
  assign RdW        = w_q.rd;
  assign ResultSrcW = w_q.result_src;
  assign ALUResultW = w_q.alu_result;
  assign ReadDataW  = w_q.read_data;
  assign PCPlus4W   = w_q.pc_plus4;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and randomized check of lsu_mem_stage against a behavioural model
module tb_lsu_mem_stage;
  import lsu_pkg::*;
  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [2:0]  res;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  ss;
    logic [2:0]  ls;
  } op_t;
  logic clk = 0, rst = 1, ack = 0;
  logic [31:0] rdata = 0;
  op_t e = '0, m = '0;
  logic wrw = 0, misq = 0;
  logic [4:0] wrd = 0;
  logic [2:0] wres = 0;
  logic [31:0] walu = 0, wdat = 0, wpc = 0;
  int cmp = 0, nerr = 0;
  logic [31:0] ALUResultM, DmemAddr, DmemWdata, ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0] RdM, RdW;
  logic [2:0] ResultSrcW;
  logic [3:0] DmemBe;
  logic RegWriteM, StallMem, DmemReq, DmemWe, RegWriteW;
`ifdef MISALIGN_TRAP_EN
  logic MisalignM;
`endif
  lsu_mem_stage dut (
    .clk(clk), .reset(rst),
    .RegWriteE(e.rw), .MemWriteE(e.mw), .ResultSrcE(e.res), .ALUResultE(e.alu),
    .WriteDataE(e.wd), .RdE(e.rd), .PCPlus4E(e.pc), .StoreSrcE(e.ss), .LoadSrcE(e.ls),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM), .StallMem(StallMem),
    .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr), .DmemWdata(DmemWdata),
    .DmemBe(DmemBe), .DmemAck(ack), .DmemRdata(rdata),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
`ifdef MISALIGN_TRAP_EN
    , .MisalignM(MisalignM)
`endif
  );
  always #5 clk = ~clk;
  logic [1:0] off;
  logic memop, mis, req, stall;
  logic [3:0] be;
  logic [31:0] wdx;
  always_comb begin
    off = m.alu[1:0];
    memop = m.mw | (m.res == RES_MEM);
    mis = 0;
`ifdef MISALIGN_TRAP_EN
    if (m.mw) mis = (m.ss == SW && off != 0) || (m.ss == SH && off % 2 == 1);
    else mis = memop && ((m.ls == LW && off != 0) || ((m.ls == LH || m.ls == LHU) && off % 2 == 1));
`endif
    req = memop & ~mis;
    stall = req & ~ack;
    be = 4'hF;
    wdx = m.wd;
    if (m.mw && m.ss == SH) begin
      be = 4'h3 << (off & 2'd2);
      wdx = (m.wd & 32'hFFFF) * 32'h10001;
    end
    if (m.mw && m.ss == SB) begin
      be = 4'h1 << off;
      wdx = (m.wd & 32'hFF) * 32'h01010101;
    end
  end
  function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [31:0] a, input logic [2:0] ls);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (ls)
      LH:  return (h ^ 32'h8000) - 32'h8000;
      LHU: return h;
      LB:  return (b ^ 32'h80) - 32'h80;
      LBU: return b;
      default: return w;
    endcase
  endfunction
  function automatic op_t nop_op();
    op_t o = '0;
    return o;
  endfunction
  function automatic op_t alu_op(input logic [4:0] rd, input logic [31:0] a);
    op_t o = '0;
    o.rw = 1; o.rd = rd; o.alu = a; o.pc = $urandom;
    return o;
  endfunction
  function automatic op_t ld_op(input logic [2:0] ls, input logic [31:0] a, input logic [4:0] rd);
    op_t o = '0;
    o.rw = 1; o.res = RES_MEM; o.ls = ls; o.alu = a; o.rd = rd; o.pc = $urandom;
    return o;
  endfunction
  function automatic op_t st_op(input logic [1:0] ss, input logic [31:0] a, input logic [31:0] wd);
    op_t o = '0;
    o.mw = 1; o.ss = ss; o.alu = a; o.wd = wd; o.rd = 5'd1; o.rw = 1; o.pc = $urandom;
    return o;
  endfunction
  function automatic op_t rand_op();
    op_t o = '0;
    int k = $urandom_range(0, 2);
    o.pc = $urandom; o.alu = $urandom; o.wd = $urandom; o.rd = 5'($urandom);
    o.rw = $urandom_range(0, 3) != 0;
    if (k == 1) begin
      o.res = RES_MEM; o.ls = 3'($urandom_range(0, 4));
    end else if (k == 2) begin
      o.mw = 1; o.ss = 2'($urandom_range(0, 2));
    end else o.res = 3'($urandom_range(0, 2) * 2);
    return o;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic sample();
    @(negedge clk);
    chk("ALUResultM", ALUResultM, m.alu);
    chk("RdM", 32'(RdM), 32'(m.rd));
    chk("RegWriteM", 32'(RegWriteM), 32'(m.rw));
    chk("StallMem", 32'(StallMem), 32'(stall));
    chk("DmemReq", 32'(DmemReq), 32'(req));
    if (req) begin
      chk("DmemWe", 32'(DmemWe), 32'(m.mw));
      chk("DmemAddr", DmemAddr, m.alu & ~32'h3);
      chk("DmemBe", 32'(DmemBe), 32'(be));
      if (m.mw) chk("DmemWdata", DmemWdata, wdx);
    end
    chk("RegWriteW", 32'(RegWriteW), 32'(wrw));
    if (wrw) begin
      chk("RdW", 32'(RdW), 32'(wrd));
      chk("ResultSrcW", 32'(ResultSrcW), 32'(wres));
      chk("ALUResultW", ALUResultW, walu);
      chk("PCPlus4W", PCPlus4W, wpc);
      if (wres == RES_MEM) chk("ReadDataW", ReadDataW, wdat);
    end
`ifdef MISALIGN_TRAP_EN
    chk("MisalignM", 32'(MisalignM), 32'(misq));
`endif
  endtask
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m = '0; wrw = 0; wrd = 0; wres = 0; walu = 0; wdat = 0; wpc = 0; misq = 0;
    end else begin
      if (req && ack) wdat = ld_val(rdata, m.alu, m.ls);
      wrw = m.rw & ~m.mw & ~stall & ~mis;
      wrd = m.rd; wres = m.res; walu = m.alu; wpc = m.pc;
      misq = misq | mis;
      if (!stall) m = e;
    end
    #1;
  endtask
  initial begin
    advance(); advance();
    sample();
    chk("rst_DmemReq", 32'(DmemReq), 0);
    chk("rst_StallMem", 32'(StallMem), 0);
    chk("rst_RegWriteW", 32'(RegWriteW), 0);
    chk("rst_ReadDataW", ReadDataW, 0);
    rst = 0; advance();
    e = st_op(SB, 32'h103, 32'hAABBCCDD); sample(); advance();
    e = nop_op(); ack = 1; sample();
    chk("sb_DmemAddr", DmemAddr, 32'h100);
    chk("sb_DmemBe", 32'(DmemBe), 32'b1000);
    chk("sb_DmemWdata", DmemWdata, 32'hDDDDDDDD);
    chk("sb_StallMem", 32'(StallMem), 0);
    advance(); ack = 0;
    sample(); chk("sb_RegWriteW", 32'(RegWriteW), 0); advance();
    e = ld_op(LB, 32'h102, 5'd7); sample(); advance();
    e = nop_op(); ack = 1; rdata = 32'h12F45678; sample(); advance(); ack = 0;
    sample(); chk("lb_ReadDataW", ReadDataW, 32'hFFFFFFF4); chk("lb_RegWriteW", 32'(RegWriteW), 1); advance();
    e = ld_op(LBU, 32'h102, 5'd8); sample(); advance();
    e = nop_op(); ack = 1; sample(); advance(); ack = 0;
    sample(); chk("lbu_ReadDataW", ReadDataW, 32'h000000F4); advance();
    e = ld_op(LW, 32'h200, 5'd9); sample(); advance();
    e = alu_op(5'd3, 32'h55);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("lw_StallMem", 32'(StallMem), 1);
      chk("lw_DmemReq", 32'(DmemReq), 1);
      chk("lw_DmemAddr", DmemAddr, 32'h200);
      chk("lw_bubble", 32'(RegWriteW), 0);
      advance();
    end
    ack = 1; rdata = 32'hCAFEF00D; sample(); chk("lw_ack_StallMem", 32'(StallMem), 0); advance(); ack = 0;
    sample();
    chk("lw_RegWriteW", 32'(RegWriteW), 1);
    chk("lw_RdW", 32'(RdW), 9);
    chk("lw_ReadDataW", ReadDataW, 32'hCAFEF00D);
    chk("lw_next_ALUResultM", ALUResultM, 32'h55);
    advance();
    e = ld_op(LW, 32'h300, 5'd4); sample(); advance();
    e = nop_op(); sample(); advance();
    rst = 1; sample(); advance(); rst = 0;
    sample();
    chk("rb_DmemReq", 32'(DmemReq), 0);
    chk("rb_RegWriteW", 32'(RegWriteW), 0);
    chk("rb_ReadDataW", ReadDataW, 0);
    chk("rb_ALUResultW", ALUResultW, 0);
    advance();
    e = ld_op(LW, 32'h102, 5'd6); sample(); advance();
    e = nop_op();
`ifdef MISALIGN_TRAP_EN
    sample(); chk("mis_DmemReq", 32'(DmemReq), 0); chk("mis_StallMem", 32'(StallMem), 0); advance();
    sample(); chk("mis_flag", 32'(MisalignM), 1); chk("mis_RegWriteW", 32'(RegWriteW), 0); advance();
    sample(); chk("mis_sticky", 32'(MisalignM), 1); advance();
`else
    ack = 1; rdata = 32'h11223344;
    sample(); chk("mis_DmemReq", 32'(DmemReq), 1); chk("mis_DmemAddr", DmemAddr, 32'h100); advance(); ack = 0;
    sample(); chk("mis_ReadDataW", ReadDataW, 32'h11223344); advance();
`endif
    e = alu_op(5'd5, 32'h1234); sample(); advance();
    e = st_op(SH, 32'h2, 32'h0000BEEF); sample();
    chk("sh_prev_ALUResultM", ALUResultM, 32'h1234); chk("sh_prev_RdM", 32'(RdM), 5); advance();
    e = nop_op(); ack = 1; sample();
    chk("sh_ALUResultM", ALUResultM, 32'h2);
    chk("sh_DmemBe", 32'(DmemBe), 32'b1100);
    chk("sh_DmemWdata", DmemWdata, 32'hBEEFBEEF);
    advance(); ack = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      e = rand_op();
      ack = req && $urandom_range(0, 2) == 0;
      rdata = $urandom;
      sample();
      advance();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, nerr);
    $finish;
  end
endmodule
